// File: rtl/de_whitening.sv
// PN9 de-whitening receiver: unmasks incoming bytes and serialises them
// LSB first, routing payload bits to fifo_out and trailing CRC bits to CRC_out.
module de_whitening #(
    parameter int CRC_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] payload_len,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       fifo_out,
    output logic       fifo_out_valid,
    output logic       CRC_out,
    output logic       CRC_out_valid,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [8:0] SEED  = 9'h1FF;
    localparam logic [8:0] CRC_W = 9'(CRC_BYTES);

    state_t     state;
    state_t     state_nxt;
    logic [8:0] lfsr;
    logic [7:0] len_q;
    logic [8:0] byte_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    logic [8:0] frame_bytes;
    logic       last_bit;
    logic       last_byte;
    logic       in_payload;

    // Eight PN9 steps, applied in the same cycle a byte is taken.
    function automatic logic [8:0] pn9_adv8(input logic [8:0] s);
        logic [8:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[0] ^ r[5], r[8:1]};
        end
        return r;
    endfunction

    assign frame_bytes = {1'b0, len_q} + CRC_W;
    assign last_bit    = (bit_cnt == 3'd7);
    assign last_byte   = ((byte_cnt + 9'd1) == frame_bytes);
    assign in_payload  = (byte_cnt < {1'b0, len_q});

    // State register; abort overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (data_in_valid) state_nxt = SHIFT;
                SHIFT: begin
                    if (last_bit) begin
                        state_nxt = last_byte ? DONE : LOAD;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: length latch, PN9 mask, shift register and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr     <= SEED;
            len_q    <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (abort) begin
            lfsr  <= SEED;
            shreg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= payload_len;
                        lfsr     <= SEED;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (data_in_valid) begin
                        shreg   <= data_in ^ lfsr[7:0];
                        lfsr    <= pn9_adv8(lfsr);
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit) begin
                        byte_cnt <= byte_cnt + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        data_in_ready  = 1'b0;
        fifo_out       = 1'b0;
        fifo_out_valid = 1'b0;
        CRC_out        = 1'b0;
        CRC_out_valid  = 1'b0;
        frame_done     = 1'b0;
        busy           = (state != IDLE);
        unique case (state)
            IDLE: ;
            LOAD: data_in_ready = 1'b1;
            SHIFT: begin
                if (in_payload) begin
                    fifo_out       = shreg[0];
                    fifo_out_valid = 1'b1;
                end else begin
                    CRC_out        = shreg[0];
                    CRC_out_valid  = 1'b1;
                end
            end
            DONE: frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_de_whitening.sv
// Randomised scoreboard bench for de_whitening: a PN9 reference model
// pushes expected bits and frame-end markers; a negedge monitor checks them.
module tb_de_whitening;

    localparam int CRC = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [1:0] kind;
        logic       b;
    } exp_t;

    localparam logic [1:0] K_FIFO = 2'd0;
    localparam logic [1:0] K_CRC  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] payload_len = 8'd0;
    logic [7:0] data_in = 8'd0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       fifo_out;
    logic       fifo_out_valid;
    logic       CRC_out;
    logic       CRC_out_valid;
    logic       busy;
    logic       frame_done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_bit_cyc = -100;
    int   fv_cnt = 0;
    int   cv_cnt = 0;
    int   consumed = 0;
    int   ready_cycs[$];
    bit   mon_en = 1'b0;
    exp_t q[$];

    de_whitening #(.CRC_BYTES(CRC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .payload_len   (payload_len),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .fifo_out      (fifo_out),
        .fifo_out_valid(fifo_out_valid),
        .CRC_out       (CRC_out),
        .CRC_out_valid (CRC_out_valid),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output event must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            checks++;
            if ((!fifo_out_valid && fifo_out) || (!CRC_out_valid && CRC_out)) begin
                errors++;
                $display("FAIL quiet_bits: fifo_out=%b CRC_out=%b with valids %b%b",
                         fifo_out, CRC_out, fifo_out_valid, CRC_out_valid);
            end
            if (data_in_ready) ready_cycs.push_back(cyc);
            if (data_in_ready && data_in_valid) consumed++;
            if (fifo_out_valid || CRC_out_valid) begin
                checks++;
                if (fifo_out_valid && CRC_out_valid) begin
                    errors++;
                    $display("FAIL valid_excl: both valids high at t=%0t", $time);
                end else if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got fifo_v=%b crc_v=%b, expected nothing",
                             fifo_out_valid, CRC_out_valid);
                end else begin
                    e = q.pop_front();
                    if (fifo_out_valid) begin
                        fv_cnt++;
                        if (e.kind != K_FIFO || e.b != fifo_out) begin
                            errors++;
                            $display("FAIL fifo_bit: got fifo=%b, expected kind=%0d bit=%b",
                                     fifo_out, e.kind, e.b);
                        end
                    end else begin
                        cv_cnt++;
                        if (e.kind != K_CRC || e.b != CRC_out) begin
                            errors++;
                            $display("FAIL crc_bit: got crc=%b, expected kind=%0d bit=%b",
                                     CRC_out, e.kind, e.b);
                        end
                    end
                end
                last_bit_cyc = cyc;
            end
            if (frame_done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got frame_done=1, expected 0");
                end else begin
                    e = q.pop_front();
                    if (e.kind != K_DONE) begin
                        errors++;
                        $display("FAIL done_order: got frame_done, expected kind=%0d", e.kind);
                    end
                end
                check("done_timing", cyc - last_bit_cyc, 1);
            end
        end
    end

    // Reference: PN9 masks from the seed, LSB-first bits, payload then CRC.
    function automatic logic [8:0] pn_step(input logic [8:0] s);
        return {s[0] ^ s[5], s[8:1]};
    endfunction

    task automatic push_model(input int len, input bq_t bytes, input int n_items);
        exp_t       items[$];
        exp_t       e;
        logic [8:0] s;
        logic [7:0] d;
        s = 9'h1FF;
        for (int i = 0; i < bytes.size(); i++) begin
            d = bytes[i] ^ s[7:0];
            for (int k = 0; k < 8; k++) s = pn_step(s);
            for (int k = 0; k < 8; k++) begin
                e.kind = (i < len) ? K_FIFO : K_CRC;
                e.b    = d[k];
                items.push_back(e);
            end
        end
        e.kind = K_DONE;
        e.b    = 1'b0;
        items.push_back(e);
        for (int i = 0; i < items.size() && (n_items < 0 || i < n_items); i++) begin
            q.push_back(items[i]);
        end
    endtask

    task automatic push_const(input logic [1:0] kind, input logic b, input int n);
        exp_t e;
        e.kind = kind;
        e.b    = b;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic start_frame(input int len);
        start       = 1'b1;
        payload_len = 8'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit keep);
        int t;
        if (!keep) data_in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        t = 0;
        while (!data_in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!data_in_ready) begin
            errors++;
            $display("FAIL ready_timeout: data_in_ready=0 after %0d cycles, expected 1", t);
        end
        @(negedge clk);
        if (!keep) data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, "_idle"}, int'(busy), 0);
        repeat (2) @(negedge clk);
        check({name, "_sb_empty"}, q.size(), 0);
    endtask

    task automatic run_frame(input string name, input int len, input bq_t bytes,
                             input int max_gap);
        start_frame(len);
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap), 1'b0);
        wait_idle(name);
    endtask

    initial begin
        bq_t bytes;
        int  len;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(data_in_ready), 0);
        check("rst_valids", int'({fifo_out_valid, CRC_out_valid}), 0);
        check("rst_bits", int'({fifo_out, CRC_out}), 0);
        check("rst_done", int'(frame_done), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Zero-data frame: masks FF E1 1D 9A cancel exactly.
        push_const(K_FIFO, 1'b0, 16);
        push_const(K_CRC, 1'b0, 16);
        push_const(K_DONE, 1'b0, 1);
        bytes = '{8'hFF, 8'hE1, 8'h1D, 8'h9A};
        run_frame("zero", 2, bytes, 0);

        // Bit order: FE ^ FF = 01, emitted LSB first.
        push_const(K_FIFO, 1'b1, 1);
        push_const(K_FIFO, 1'b0, 7);
        push_const(K_CRC, 1'b0, 16);
        push_const(K_DONE, 1'b0, 1);
        bytes = '{8'hFE, 8'hE1, 8'h1D};
        run_frame("order", 1, bytes, 2);

        // Empty payload: everything goes to CRC_out.
        fv_cnt = 0;
        cv_cnt = 0;
        bytes  = '{8'($urandom), 8'($urandom)};
        push_model(0, bytes, -1);
        run_frame("len0", 0, bytes, 1);
        check("len0_fifo_valids", fv_cnt, 0);
        check("len0_crc_valids", cv_cnt, 16);

        // Random frames with random input gaps.
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(0, 4);
            bytes.delete();
            for (int i = 0; i < len + CRC; i++) bytes.push_back(8'($urandom));
            push_model(len, bytes, -1);
            run_frame("rand", len, bytes, 3);
        end

        // Backpressure: data_in_valid held high throughout the frame.
        len = 3;
        bytes.delete();
        for (int i = 0; i < len + CRC; i++) bytes.push_back(8'($urandom));
        push_model(len, bytes, -1);
        data_in_valid = 1'b1;
        ready_cycs.delete();
        consumed = 0;
        start_frame(len);
        foreach (bytes[i]) send_byte(bytes[i], 0, 1'b1);
        wait_idle("bp");
        repeat (3) @(negedge clk);
        data_in_valid = 1'b0;
        check("bp_consumed", consumed, len + CRC);
        check("bp_ready_cycles", ready_cycs.size(), len + CRC);
        for (int i = 1; i < ready_cycs.size(); i++) begin
            check("bp_ready_spacing", ready_cycs[i] - ready_cycs[i-1], 9);
        end

        // Abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_idle", int'(busy), 0);

        // Abort during the first bit of byte 1.
        bytes = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        push_model(2, bytes, 9);
        start_frame(2);
        send_byte(bytes[0], 0, 1'b0);
        send_byte(bytes[1], 0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_valids", int'({fifo_out_valid, CRC_out_valid, data_in_ready}), 0);
        repeat (4) @(negedge clk);
        check("abort_sb_empty", q.size(), 0);
        push_const(K_FIFO, 1'b1, 8);
        push_const(K_CRC, 1'b0, 16);
        push_const(K_DONE, 1'b0, 1);
        bytes = '{8'h00, 8'hE1, 8'h1D};
        run_frame("post_abort", 1, bytes, 1);

        // Reset pulse during SHIFT, with start held during reset.
        bytes = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        push_model(2, bytes, 3);
        start_frame(2);
        send_byte(bytes[0], 0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b0;
        start       = 1'b1;
        payload_len = 8'd5;
        @(negedge clk);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_outs", int'({data_in_ready, fifo_out, fifo_out_valid,
                                   CRC_out, CRC_out_valid, frame_done}), 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_start_ignored", int'(busy), 0);
        check("rstmid_sb_empty", q.size(), 0);

        // First frame after reset must start from seed mask FF.
        len = 2;
        bytes = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        push_model(len, bytes, -1);
        run_frame("post_reset", len, bytes, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
